hazard_scoreboard: RTL and testbench

Issue-side hazard unit for the 4-stage integer pipeline: tracks every in-flight destination register produced by the ALU, load, multiply and divide units. It stalls ID on RAW/WAW/structural hazards and publishes each unit's completing `Rd` with a valid qualifier. Those signals feed the forwarding unit's `alu_Rd/ld_Rd/mul_Rd/div_Rd` comparisons and the register-file write ports.

---
 rtl/hazard_scoreboard.sv | 159 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard for the 4-stage integer pipeline: tracks pending
// destination writes per unit, stalls ID on RAW/WAW/structural hazards, publishes completions.
module hazard_scoreboard #(
  parameter int unsigned LD_LAT  = 2,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_vld,
  input  logic [1:0]  issue_unit,
  input  logic        issue_wr,
  input  logic [3:0]  issue_Rd,
  input  logic [3:0]  issue_Rs1,
  input  logic [3:0]  issue_Rs2,
  input  logic        issue_use1,
  input  logic        issue_use2,
  output logic        stall,
  output logic        issue_ack,
  output logic [3:0]  alu_Rd,
  output logic [3:0]  ld_Rd,
  output logic [3:0]  mul_Rd,
  output logic [3:0]  div_Rd,
  output logic        alu_vld,
  output logic        ld_vld,
  output logic        mul_vld,
  output logic        div_vld,
  output logic [15:0] busy
);

  typedef enum logic [1:0] {UNIT_ALU, UNIT_LD, UNIT_MUL, UNIT_DIV} unit_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  localparam int unsigned CW = $clog2(DIV_LAT + 1);

  logic [15:0] busy_q;
  logic [1:0]  owner_q [16];

  logic        alu_vld_q;
  logic [3:0]  alu_rd_q;
  logic [LD_LAT-1:0]  ld_vld_sr;
  logic [3:0]         ld_rd_sr [LD_LAT];
  logic [MUL_LAT-1:0] mul_vld_sr;
  logic [3:0]         mul_rd_sr [MUL_LAT];

  div_state_e  div_state_q, div_state_n;
  logic [CW-1:0] div_cnt_q;
  logic [3:0]  div_tag_q;
  logic        div_wr_q;

  logic [15:0] complete_vec, clr_vec, set_vec;
  logic raw1, raw2, waw, div_struct;
  logic acc_alu, acc_ld, acc_mul, acc_div, acc_wr;

  assign alu_vld = alu_vld_q;
  assign alu_Rd  = alu_rd_q;
  assign ld_vld  = ld_vld_sr[LD_LAT-1];
  assign ld_Rd   = ld_rd_sr[LD_LAT-1];
  assign mul_vld = mul_vld_sr[MUL_LAT-1];
  assign mul_Rd  = mul_rd_sr[MUL_LAT-1];
  assign div_vld = (div_state_q == DIV_DONE) & div_wr_q;
  assign div_Rd  = div_tag_q;
  assign busy    = busy_q;

  // Only the recorded owner clears a busy bit; WAW stalling keeps one writer per register.
  always_comb begin
    complete_vec = '0;
    clr_vec      = '0;
    if (alu_vld) begin
      complete_vec[alu_Rd] = 1'b1;
      if (owner_q[alu_Rd] == UNIT_ALU) clr_vec[alu_Rd] = 1'b1;
    end
    if (ld_vld) begin
      complete_vec[ld_Rd] = 1'b1;
      if (owner_q[ld_Rd] == UNIT_LD) clr_vec[ld_Rd] = 1'b1;
    end
    if (mul_vld) begin
      complete_vec[mul_Rd] = 1'b1;
      if (owner_q[mul_Rd] == UNIT_MUL) clr_vec[mul_Rd] = 1'b1;
    end
    if (div_vld) begin
      complete_vec[div_Rd] = 1'b1;
      if (owner_q[div_Rd] == UNIT_DIV) clr_vec[div_Rd] = 1'b1;
    end
  end

  always_comb begin
    raw1       = issue_use1 & busy_q[issue_Rs1] & ~complete_vec[issue_Rs1];
    raw2       = issue_use2 & busy_q[issue_Rs2] & ~complete_vec[issue_Rs2];
    waw        = issue_wr & busy_q[issue_Rd] & ~complete_vec[issue_Rd];
    div_struct = (issue_unit == UNIT_DIV) & (div_state_q == DIV_RUN);
    stall      = issue_vld & (raw1 | raw2 | waw | div_struct);
    issue_ack  = issue_vld & ~stall & ~rst;
    acc_alu    = issue_ack & (issue_unit == UNIT_ALU);
    acc_ld     = issue_ack & (issue_unit == UNIT_LD);
    acc_mul    = issue_ack & (issue_unit == UNIT_MUL);
    acc_div    = issue_ack & (issue_unit == UNIT_DIV);
    acc_wr     = issue_ack & issue_wr;
    set_vec    = acc_wr ? (16'h0001 << issue_Rd) : '0;
  end

  always_comb begin
    div_state_n = div_state_q;
    case (div_state_q)
      DIV_IDLE: if (acc_div) div_state_n = DIV_RUN;
      DIV_RUN:  if (div_cnt_q == CW'(2)) div_state_n = DIV_DONE;
      DIV_DONE: div_state_n = acc_div ? DIV_RUN : DIV_IDLE;
      default:  div_state_n = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      alu_vld_q   <= 1'b0;
      alu_rd_q    <= '0;
      ld_vld_sr   <= '0;
      mul_vld_sr  <= '0;
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
      div_tag_q   <= '0;
      div_wr_q    <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) owner_q[i] <= '0;
      for (int unsigned i = 0; i < LD_LAT; i++) ld_rd_sr[i] <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) mul_rd_sr[i] <= '0;
    end else begin
      // Set after clear so a same-edge reissue of a completing register stays busy.
      busy_q <= (busy_q & ~clr_vec) | set_vec;
      if (acc_wr) owner_q[issue_Rd] <= issue_unit;

      alu_vld_q <= acc_alu & issue_wr;
      alu_rd_q  <= acc_alu ? issue_Rd : '0;

      ld_vld_sr[0] <= acc_ld & issue_wr;
      ld_rd_sr[0]  <= acc_ld ? issue_Rd : '0;
      for (int unsigned i = 1; i < LD_LAT; i++) begin
        ld_vld_sr[i] <= ld_vld_sr[i-1];
        ld_rd_sr[i]  <= ld_rd_sr[i-1];
      end

      mul_vld_sr[0] <= acc_mul & issue_wr;
      mul_rd_sr[0]  <= acc_mul ? issue_Rd : '0;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        mul_vld_sr[i] <= mul_vld_sr[i-1];
        mul_rd_sr[i]  <= mul_rd_sr[i-1];
      end

      div_state_q <= div_state_n;
      if (acc_div) begin
        div_cnt_q <= CW'(DIV_LAT);
        div_tag_q <= issue_Rd;
        div_wr_q  <= issue_wr;
      end else if (div_cnt_q != '0) begin
        div_cnt_q <= div_cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized issue traffic
// checked against an event-time model of pending register writes.
module tb_hazard_scoreboard;
  localparam int LD_LAT = 2, MUL_LAT = 3, DIV_LAT = 8;

  logic clk = 1'b0;
  logic rst, issue_vld, issue_wr, issue_use1, issue_use2, stall, issue_ack;
  logic [1:0] issue_unit;
  logic [3:0] issue_Rd, issue_Rs1, issue_Rs2, alu_Rd, ld_Rd, mul_Rd, div_Rd;
  logic alu_vld, ld_vld, mul_vld, div_vld;
  logic [15:0] busy;

  hazard_scoreboard #(.LD_LAT(LD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .issue_vld(issue_vld), .issue_unit(issue_unit),
    .issue_wr(issue_wr), .issue_Rd(issue_Rd), .issue_Rs1(issue_Rs1), .issue_Rs2(issue_Rs2),
    .issue_use1(issue_use1), .issue_use2(issue_use2), .stall(stall), .issue_ack(issue_ack),
    .alu_Rd(alu_Rd), .ld_Rd(ld_Rd), .mul_Rd(mul_Rd), .div_Rd(div_Rd),
    .alu_vld(alu_vld), .ld_vld(ld_vld), .mul_vld(mul_vld), .div_vld(div_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each pending write is just "register r is written by unit u at cycle done_at[r]".
  int cyc = 0;
  bit pend [16];
  int done_at [16];
  int own [16];
  int div_done = 0;

  function automatic int lat(int u);
    case (u)
      0: return 1;
      1: return LD_LAT;
      2: return MUL_LAT;
      default: return DIV_LAT;
    endcase
  endfunction

  function automatic bit m_complete(int r);
    return pend[r] && done_at[r] == cyc;
  endfunction

  function automatic bit m_stall();
    bit s;
    if (!issue_vld) return 1'b0;
    s = (issue_use1 && pend[issue_Rs1] && !m_complete(int'(issue_Rs1)))
     || (issue_use2 && pend[issue_Rs2] && !m_complete(int'(issue_Rs2)))
     || (issue_wr && pend[issue_Rd] && !m_complete(int'(issue_Rd)))
     || (issue_unit == 2'd3 && cyc < div_done);
    return s;
  endfunction

  function automatic bit m_vld(int u);
    for (int r = 0; r < 16; r++) if (m_complete(r) && own[r] == u) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_rd(int u);
    for (int r = 0; r < 16; r++) if (m_complete(r) && own[r] == u) return r;
    return 0;
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    for (int r = 0; r < 16; r++) b[r] = pend[r];
    return b;
  endfunction

  function automatic logic dut_vld(int u);
    case (u)
      0: return alu_vld;
      1: return ld_vld;
      2: return mul_vld;
      default: return div_vld;
    endcase
  endfunction

  function automatic logic [3:0] dut_rd(int u);
    case (u)
      0: return alu_Rd;
      1: return ld_Rd;
      2: return mul_Rd;
      default: return div_Rd;
    endcase
  endfunction

  task automatic set_in(bit v, int u, bit w, int rd, int s1, int s2, bit u1, bit u2);
    issue_vld = v; issue_unit = 2'(u); issue_wr = w; issue_Rd = 4'(rd);
    issue_Rs1 = 4'(s1); issue_Rs2 = 4'(s2); issue_use1 = u1; issue_use2 = u2;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Apply the current inputs at the next edge to the model, then move to the next cycle.
  task automatic advance();
    bit acc;
    acc = issue_vld && !m_stall() && !rst;
    for (int r = 0; r < 16; r++) if (m_complete(r)) pend[r] = 1'b0;
    if (rst) begin
      for (int r = 0; r < 16; r++) pend[r] = 1'b0;
      div_done = 0;
    end else if (acc) begin
      if (issue_unit == 2'd3) div_done = cyc + DIV_LAT;
      if (issue_wr) begin
        pend[issue_Rd] = 1'b1;
        done_at[issue_Rd] = cyc + lat(int'(issue_unit));
        own[issue_Rd] = int'(issue_unit);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    idle_in();
    for (int i = 0; i < DIV_LAT + 2; i++) advance();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 0, 1, 5, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (issue_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", issue_ack); end
    advance();
    advance();
    rst = 1'b0;
    idle_in();
    @(negedge clk);
    n_tests++; if (busy !== 16'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0000", busy); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_tests++; if ({alu_vld, ld_vld, mul_vld, div_vld} !== 4'b0) begin
      n_fail++; $display("FAIL reset_vld: got %b want 0000", {alu_vld, ld_vld, mul_vld, div_vld}); end
    n_tests++; if ({alu_Rd, ld_Rd, mul_Rd, div_Rd} !== 16'h0) begin
      n_fail++; $display("FAIL reset_rd: got %h want 0000", {alu_Rd, ld_Rd, mul_Rd, div_Rd}); end
  endtask

  task automatic test_alu();
    set_in(1, 0, 1, 5, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (issue_ack !== 1'b1) begin n_fail++; $display("FAIL alu_ack: got %b want 1", issue_ack); end
    advance();
    idle_in();
    @(negedge clk);
    n_tests++; if (alu_vld !== 1'b1 || alu_Rd !== 4'd5) begin
      n_fail++; $display("FAIL alu_t1: vld=%b rd=%0d want 1/5", alu_vld, alu_Rd); end
    n_tests++; if (busy[5] !== 1'b1) begin n_fail++; $display("FAIL alu_busy_t1: got %b want 1", busy[5]); end
    advance();
    @(negedge clk);
    n_tests++; if (busy[5] !== 1'b0 || alu_vld !== 1'b0) begin
      n_fail++; $display("FAIL alu_t2: busy5=%b vld=%b want 0/0", busy[5], alu_vld); end
    drain();
  endtask

  task automatic test_raw_ld();
    set_in(1, 1, 1, 3, 0, 0, 0, 0);
    advance();
    set_in(1, 0, 1, 8, 3, 0, 1, 0);
    @(negedge clk);
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_t1: got %b want 1", stall); end
    advance();
    @(negedge clk);
    n_tests++; if (stall !== 1'b0 || issue_ack !== 1'b1) begin
      n_fail++; $display("FAIL raw_t2: stall=%b ack=%b want 0/1", stall, issue_ack); end
    n_tests++; if (ld_vld !== 1'b1 || ld_Rd !== 4'd3) begin
      n_fail++; $display("FAIL raw_ld_t2: vld=%b rd=%0d want 1/3", ld_vld, ld_Rd); end
    advance();
    idle_in();
    @(negedge clk);
    n_tests++; if (alu_vld !== 1'b1 || alu_Rd !== 4'd8) begin
      n_fail++; $display("FAIL raw_alu_t3: vld=%b rd=%0d want 1/8", alu_vld, alu_Rd); end
    drain();
  endtask

  task automatic test_div_back_to_back();
    set_in(1, 3, 1, 7, 0, 0, 0, 0);
    advance();
    set_in(1, 3, 1, 10, 0, 0, 0, 0);
    for (int t = 1; t < DIV_LAT; t++) begin
      @(negedge clk);
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL div_struct_t%0d: got %b want 1", t, stall); end
      advance();
    end
    @(negedge clk);
    n_tests++; if (stall !== 1'b0 || issue_ack !== 1'b1) begin
      n_fail++; $display("FAIL div_accept_t8: stall=%b ack=%b want 0/1", stall, issue_ack); end
    n_tests++; if (div_vld !== 1'b1 || div_Rd !== 4'd7) begin
      n_fail++; $display("FAIL div_done_t8: vld=%b rd=%0d want 1/7", div_vld, div_Rd); end
    advance();
    idle_in();
    for (int t = DIV_LAT + 1; t < 2 * DIV_LAT; t++) begin
      @(negedge clk);
      n_tests++; if (div_vld !== 1'b0) begin n_fail++; $display("FAIL div_quiet_t%0d: got %b want 0", t, div_vld); end
      advance();
    end
    @(negedge clk);
    n_tests++; if (div_vld !== 1'b1 || div_Rd !== 4'd10) begin
      n_fail++; $display("FAIL div_second_t16: vld=%b rd=%0d want 1/10", div_vld, div_Rd); end
    drain();
  endtask

  task automatic test_waw();
    set_in(1, 2, 1, 4, 0, 0, 0, 0);
    advance();
    set_in(1, 0, 1, 4, 0, 0, 0, 0);
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall_t%0d: got %b want 1", t, stall); end
      advance();
    end
    @(negedge clk);
    n_tests++; if (stall !== 1'b0 || mul_vld !== 1'b1 || mul_Rd !== 4'd4) begin
      n_fail++; $display("FAIL waw_t3: stall=%b mul_vld=%b mul_rd=%0d want 0/1/4", stall, mul_vld, mul_Rd); end
    advance();
    idle_in();
    @(negedge clk);
    n_tests++; if (busy[4] !== 1'b1 || alu_vld !== 1'b1 || alu_Rd !== 4'd4) begin
      n_fail++; $display("FAIL waw_t4: busy4=%b alu_vld=%b alu_rd=%0d want 1/1/4", busy[4], alu_vld, alu_Rd); end
    advance();
    @(negedge clk);
    n_tests++; if (busy[4] !== 1'b0) begin n_fail++; $display("FAIL waw_t5: busy4=%b want 0", busy[4]); end
    drain();
  endtask

  task automatic test_mul_pipelined();
    int rds [3] = '{2, 6, 9};
    for (int t = 0; t < 3; t++) begin
      set_in(1, 2, 1, rds[t], 0, 0, 0, 0);
      @(negedge clk);
      n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mul_issue_t%0d: stall=%b want 0", t, stall); end
      advance();
    end
    idle_in();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      n_tests++; if (mul_vld !== 1'b1 || mul_Rd !== 4'(rds[t])) begin
        n_fail++; $display("FAIL mul_done_t%0d: vld=%b rd=%0d want 1/%0d", t + 3, mul_vld, mul_Rd, rds[t]); end
      advance();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    set_in(1, 3, 1, 1, 0, 0, 0, 0);
    advance();
    idle_in();
    advance();
    advance();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_t3: got %b want 1", busy[1]); end
    advance();
    rst = 1'b0;
    set_in(1, 3, 1, 11, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++; if (busy !== 16'h0 || stall !== 1'b0 || issue_ack !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_t4: busy=%h stall=%b ack=%b want 0000/0/1", busy, stall, issue_ack); end
    advance();
    idle_in();
    for (int t = 5; t < 4 + DIV_LAT; t++) begin
      @(negedge clk);
      n_tests++; if (div_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet_t%0d: got %b want 0", t, div_vld); end
      advance();
    end
    @(negedge clk);
    n_tests++; if (div_vld !== 1'b1 || div_Rd !== 4'd11) begin
      n_fail++; $display("FAIL rstmid_done_t12: vld=%b rd=%0d want 1/11", div_vld, div_Rd); end
    drain();
  endtask

  task automatic test_random();
    bit exp_ack;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      set_in($urandom_range(0, 9) < 7, int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom));
      @(negedge clk);
      exp_ack = issue_vld && !m_stall() && !rst;
      n_tests++; if (stall !== m_stall()) begin
        n_fail++; $display("FAIL rnd_stall cyc%0d: got %b want %b", cyc, stall, m_stall()); end
      n_tests++; if (issue_ack !== exp_ack) begin
        n_fail++; $display("FAIL rnd_ack cyc%0d: got %b want %b", cyc, issue_ack, exp_ack); end
      n_tests++; if (busy !== m_busy()) begin
        n_fail++; $display("FAIL rnd_busy cyc%0d: got %h want %h", cyc, busy, m_busy()); end
      for (int u = 0; u < 4; u++) begin
        n_tests++; if (dut_vld(u) !== m_vld(u)) begin
          n_fail++; $display("FAIL rnd_vld%0d cyc%0d: got %b want %b", u, cyc, dut_vld(u), m_vld(u)); end
        if (m_vld(u)) begin
          n_tests++; if (dut_rd(u) !== 4'(m_rd(u))) begin
            n_fail++; $display("FAIL rnd_rd%0d cyc%0d: got %0d want %0d", u, cyc, dut_rd(u), m_rd(u)); end
        end
      end
      advance();
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_raw_ld();
    test_div_back_to_back();
    test_waw();
    test_mul_pipelined();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
